vending_credit_fsm: RTL and testbench
=====================================

Name: vending_credit_fsm

Overview:
Parametrised successor to the fixed-price 5/10 Mealy vending controller. Accumulates credit in 5-cent units from a 2-bit coin input, including an optional 25-cent coin. Vends at a configurable price and supports a cancel/refund request. Returns change (or a full refund) one 5-cent unit at a time over a valid/ready handshake; all outputs are registered.

Parameters:
PRICE_UNITS, 4, item price in 5-cent units (4 = 20c); legal range 1..2^CREDIT_W-6
CREDIT_W, 6, credit register width; must hold PRICE_UNITS-1+5
COIN25_EN, 1, 1 = coin code 2'b11 accepted as 25c; 0 = code 11 rejected

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-low reset
coin  input  2  00 none, 01 5c, 10 10c, 11 25c; sampled every clk edge, one code per cycle
cancel  input  1  refund request, sampled per cycle
chg_ready  input  1  downstream change hopper accepts one 5c unit
dispense  output  1  one-cycle vend pulse
chg_valid  output  1  a 5c change unit is offered
coin_rej  output  1  one-cycle pulse: coin not credited (return it)
credit  output  CREDIT_W  current credit/owed change in 5c units
busy  output  1  high while in CHANGE state

Behaviour:
- Reset (rst=0, asynchronous): state=COLLECT, credit=0, dispense=chg_valid=coin_rej=busy=0. Reset mid-CHANGE forfeits owed change.
- Coin value v: 01->1, 10->2, 11->5 if COIN25_EN else invalid; 00->0.
- States: COLLECT, CHANGE. Outputs are registered; pulses appear the cycle after the triggering edge.
- COLLECT, valid coin, sum=credit+v:
  - sum>=PRICE_UNITS: dispense=1 next cycle; credit<=sum-PRICE_UNITS; if the remainder >0, go to CHANGE, else stay in COLLECT.
  - sum<PRICE_UNITS: credit<=sum.
- COLLECT, invalid coin (11 with COIN25_EN=0): coin_rej=1 next cycle, credit unchanged.
- COLLECT, cancel=1:
  - With no vend that cycle and sum>0 (coin, if any, added first): no dispense, credit<=sum, go to CHANGE.
  - If the same-cycle coin triggers a vend, cancel is ignored; normal change applies.
  - cancel with credit=0 and no coin: no effect.
- CHANGE:
  - chg_valid=1 and busy=1 from the entry cycle on.
  - Each edge with chg_valid&&chg_ready decrements credit by 1.
  - When the decrement takes credit to 0: state goes to COLLECT; chg_valid and busy are 0 the next cycle.
  - chg_valid must not drop while credit>0, regardless of chg_ready.
  - A nonzero coin in CHANGE is not credited: coin_rej=1 next cycle.
  - cancel in CHANGE is ignored.
- dispense and coin_rej never assert in the same cycle; dispense never asserts in CHANGE.
- Arithmetic is unsigned, CREDIT_W bits; parameter limits guarantee no overflow. Include a simulation assertion on the parameter range.

Decomposition:
- Package vending_pkg: coin encodings (COIN_NONE/5/10/25), state enum {COLLECT, CHANGE}, function coin_units(code, coin25_en) returning value plus a valid flag.
- Single module; no sub-module needed (decode is a package function).

Test Plan:
1. Defaults: 10,10 (each coin one cycle, then 00) -> dispense pulse 1 cycle after the second coin; credit=0; chg_valid never high.
2. 10,5,10 with chg_ready=1 -> dispense pulse; credit=1; chg_valid high exactly 1 cycle; returns to COLLECT with credit=0.
3. 5,10,5 (credit 4?) must vend on the third coin. Then coin sequence 10,5 (credit 3), then 25 -> dispense; credit=4. Hold chg_ready=0 for 3 cycles: chg_valid stays 1 and credit stays 4. Then chg_ready=1: exactly 4 handshakes, credit 4->0.
4. 5,10, then cancel -> no dispense; credit=3; 3 change handshakes. Cancel asserted together with the 10c coin that completes 20c -> dispense, no refund.
5. Coin 10 during CHANGE -> coin_rej pulse, credit unchanged. With COIN25_EN=0, coin 11 in COLLECT -> coin_rej, credit unchanged.
6. rst low asynchronously mid-CHANGE (credit=3) -> chg_valid, busy, credit go to 0 without a clock edge. After release, 10,10 -> normal vend.

Source files
------------

// File: rtl/vending_pkg.sv
// Shared decode for the vending credit controller: coin encodings, FSM states, coin value lookup.
package vending_pkg;

  localparam logic [1:0] COIN_NONE = 2'b00;
  localparam logic [1:0] COIN_5    = 2'b01;
  localparam logic [1:0] COIN_10   = 2'b10;
  localparam logic [1:0] COIN_25   = 2'b11;

  typedef enum logic [0:0] {
    COLLECT = 1'b0,
    CHANGE  = 1'b1
  } state_e;

  typedef struct packed {
    logic       valid;
    logic [2:0] units;
  } coin_val_t;

  // COIN_NONE decodes as a valid zero-value coin so callers only reject on !valid.
  function automatic coin_val_t coin_units(input logic [1:0] code, input logic coin25_en);
    coin_val_t r;
    r.valid = 1'b1;
    r.units = 3'd0;
    case (code)
      COIN_5:  r.units = 3'd1;
      COIN_10: r.units = 3'd2;
      COIN_25: begin
        r.valid = coin25_en;
        r.units = coin25_en ? 3'd5 : 3'd0;
      end
      default: r.units = 3'd0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/vending_credit_fsm.sv
// Coin-credit vending controller: vends at PRICE_UNITS, refunds/returns change one 5c unit per handshake.
// All outputs registered; change offer held until the hopper accepts, never dropped while credit > 0.
module vending_credit_fsm
  import vending_pkg::*;
#(
  parameter int PRICE_UNITS = 4,
  parameter int CREDIT_W    = 6,
  parameter bit COIN25_EN   = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [1:0]          coin,
  input  logic                cancel,
  input  logic                chg_ready,
  output logic                dispense,
  output logic                chg_valid,
  output logic                coin_rej,
  output logic [CREDIT_W-1:0] credit,
  output logic                busy
);

  localparam logic [CREDIT_W-1:0] PRICE = CREDIT_W'(PRICE_UNITS);

  state_e                state_q, state_d;
  logic [CREDIT_W-1:0]   credit_q, credit_d;
  logic                  dispense_q, dispense_d;
  logic                  coin_rej_q, coin_rej_d;

  coin_val_t             cv;
  logic [CREDIT_W-1:0]   sum;

  always_comb begin
    cv         = coin_units(coin, COIN25_EN);
    sum        = credit_q + CREDIT_W'(cv.units);
    state_d    = state_q;
    credit_d   = credit_q;
    dispense_d = 1'b0;
    coin_rej_d = 1'b0;

    case (state_q)
      COLLECT: begin
        if (!cv.valid) begin
          coin_rej_d = 1'b1;
        end
        // A vend takes priority over a same-cycle cancel; the remainder goes out as change.
        if (sum >= PRICE) begin
          dispense_d = 1'b1;
          credit_d   = sum - PRICE;
          if (sum != PRICE) begin
            state_d = CHANGE;
          end
        end else begin
          credit_d = sum;
          if (cancel && (sum != '0)) begin
            state_d = CHANGE;
          end
        end
      end

      CHANGE: begin
        if (coin != COIN_NONE) begin
          coin_rej_d = 1'b1;
        end
        if (chg_ready) begin
          credit_d = credit_q - 1'b1;
          if (credit_q == CREDIT_W'(1)) begin
            state_d = COLLECT;
          end
        end
      end

      default: begin
        state_d  = COLLECT;
        credit_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= COLLECT;
      credit_q   <= '0;
      dispense_q <= 1'b0;
      coin_rej_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      credit_q   <= credit_d;
      dispense_q <= dispense_d;
      coin_rej_q <= coin_rej_d;
    end
  end

  // CHANGE is only ever occupied with credit > 0, so the state flop doubles as the change offer.
  assign dispense  = dispense_q;
  assign coin_rej  = coin_rej_q;
  assign credit    = credit_q;
  assign busy      = (state_q == CHANGE);
  assign chg_valid = (state_q == CHANGE);

  always_ff @(posedge clk) begin
    assert (PRICE_UNITS >= 1 && PRICE_UNITS <= (1 << CREDIT_W) - 6)
      else $error("vending_credit_fsm: PRICE_UNITS %0d out of range for CREDIT_W %0d",
                  PRICE_UNITS, CREDIT_W);
  end

endmodule

// File: tb/tb_vending_credit_fsm.sv
// Directed bench for vending_credit_fsm: default build plus a COIN25_EN=0 build for the reject path.
module tb_vending_credit_fsm;

  logic       clk;
  logic       rst;
  logic [1:0] coin;
  logic       cancel;
  logic       chg_ready;
  logic       dispense;
  logic       chg_valid;
  logic       coin_rej;
  logic [5:0] credit;
  logic       busy;

  logic [1:0] coin2;
  logic       dispense2;
  logic       chg_valid2;
  logic       coin_rej2;
  logic [5:0] credit2;
  logic       busy2;

  int n_vec;
  int n_err;

  vending_credit_fsm #(.PRICE_UNITS(4), .CREDIT_W(6), .COIN25_EN(1'b1)) dut (
    .clk       (clk),
    .rst       (rst),
    .coin      (coin),
    .cancel    (cancel),
    .chg_ready (chg_ready),
    .dispense  (dispense),
    .chg_valid (chg_valid),
    .coin_rej  (coin_rej),
    .credit    (credit),
    .busy      (busy)
  );

  vending_credit_fsm #(.PRICE_UNITS(4), .CREDIT_W(6), .COIN25_EN(1'b0)) dut_no25 (
    .clk       (clk),
    .rst       (rst),
    .coin      (coin2),
    .cancel    (1'b0),
    .chg_ready (1'b1),
    .dispense  (dispense2),
    .chg_valid (chg_valid2),
    .coin_rej  (coin_rej2),
    .credit    (credit2),
    .busy      (busy2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_vec++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Apply one cycle of inputs; returns 1ns after the capturing edge.
  task automatic cyc(input logic [1:0] c, input logic cn, input logic rdy);
    coin      = c;
    cancel    = cn;
    chg_ready = rdy;
    @(posedge clk);
    #1;
    coin   = 2'b00;
    cancel = 1'b0;
  endtask

  task automatic outs(input string tag, input int disp, input int cv, input int rej, input int cred);
    chk({tag, ".dispense"},  int'(dispense),  disp);
    chk({tag, ".chg_valid"}, int'(chg_valid), cv);
    chk({tag, ".coin_rej"},  int'(coin_rej),  rej);
    chk({tag, ".credit"},    int'(credit),    cred);
  endtask

  initial begin
    n_vec     = 0;
    n_err     = 0;
    rst       = 1'b0;
    coin      = 2'b00;
    coin2     = 2'b00;
    cancel    = 1'b0;
    chg_ready = 1'b0;
    #12;
    outs("reset", 0, 0, 0, 0);
    chk("reset.busy", int'(busy), 0);
    rst = 1'b1;

    // 1: 10+10 vends exactly, no change
    cyc(2'b10, 0, 0); outs("t1.c1", 0, 0, 0, 2);
    cyc(2'b10, 0, 0); outs("t1.c2", 1, 0, 0, 0);
    cyc(2'b00, 0, 0); outs("t1.idle", 0, 0, 0, 0);

    // 2: 10,5,10 -> vend with one unit of change
    cyc(2'b10, 0, 1); outs("t2.c1", 0, 0, 0, 2);
    cyc(2'b01, 0, 1); outs("t2.c2", 0, 0, 0, 3);
    cyc(2'b10, 0, 1); outs("t2.c3", 1, 1, 0, 1);
    chk("t2.busy", int'(busy), 1);
    cyc(2'b00, 0, 1); outs("t2.hs", 0, 0, 0, 0);
    chk("t2.busy_end", int'(busy), 0);

    // 3: 5,10,5 vends; then 10,5,25 -> 4 units change with stalled hopper
    cyc(2'b01, 0, 0); outs("t3.a1", 0, 0, 0, 1);
    cyc(2'b10, 0, 0); outs("t3.a2", 0, 0, 0, 3);
    cyc(2'b01, 0, 0); outs("t3.a3", 1, 0, 0, 0);
    cyc(2'b10, 0, 0); outs("t3.b1", 0, 0, 0, 2);
    cyc(2'b01, 0, 0); outs("t3.b2", 0, 0, 0, 3);
    cyc(2'b11, 0, 0); outs("t3.b3", 1, 1, 0, 4);
    for (int i = 0; i < 3; i++) begin
      cyc(2'b00, 0, 0); outs($sformatf("t3.stall%0d", i), 0, 1, 0, 4);
    end
    for (int i = 0; i < 4; i++) begin
      cyc(2'b00, 0, 1);
      outs($sformatf("t3.hs%0d", i), 0, (i < 3) ? 1 : 0, 0, 3 - i);
    end
    chk("t3.busy_end", int'(busy), 0);

    // 4: cancel refunds; cancel with a completing coin vends instead
    cyc(2'b01, 0, 0); outs("t4.c1", 0, 0, 0, 1);
    cyc(2'b10, 0, 0); outs("t4.c2", 0, 0, 0, 3);
    cyc(2'b00, 1, 0); outs("t4.cancel", 0, 1, 0, 3);
    for (int i = 0; i < 3; i++) begin
      cyc(2'b00, 0, 1);
      outs($sformatf("t4.hs%0d", i), 0, (i < 2) ? 1 : 0, 0, 2 - i);
    end
    cyc(2'b10, 0, 0); outs("t4.d1", 0, 0, 0, 2);
    cyc(2'b10, 1, 0); outs("t4.d2", 1, 0, 0, 0);
    cyc(2'b00, 1, 0); outs("t4.d3", 0, 0, 0, 0);

    // 5: coin during CHANGE rejected; code 11 rejected when 25c disabled
    cyc(2'b10, 0, 0); outs("t5.c1", 0, 0, 0, 2);
    cyc(2'b01, 0, 0); outs("t5.c2", 0, 0, 0, 3);
    cyc(2'b00, 1, 0); outs("t5.cancel", 0, 1, 0, 3);
    cyc(2'b10, 0, 0); outs("t5.rej", 0, 1, 1, 3);
    cyc(2'b00, 1, 0); outs("t5.hold", 0, 1, 0, 3);

    coin2 = 2'b10;
    @(posedge clk); #1;
    coin2 = 2'b11;
    @(posedge clk); #1;
    coin2 = 2'b00;
    chk("t5.no25.rej",    int'(coin_rej2),  1);
    chk("t5.no25.credit", int'(credit2),    2);
    chk("t5.no25.disp",   int'(dispense2),  0);
    chk("t5.no25.busy",   int'(busy2),      0);
    chk("t5.chg.credit",  int'(credit),     3);

    // 6: asynchronous reset mid-CHANGE, then a normal vend
    #2 rst = 1'b0;
    #1;
    chk("t6.rst.credit",    int'(credit),    0);
    chk("t6.rst.chg_valid", int'(chg_valid), 0);
    chk("t6.rst.busy",      int'(busy),      0);
    #2 rst = 1'b1;
    cyc(2'b10, 0, 0); outs("t6.c1", 0, 0, 0, 2);
    cyc(2'b10, 0, 0); outs("t6.c2", 1, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
